// File: rtl/comb_phase_scheduler_if.sv
// Handshake bundle between the combination-phase scheduler and its control/datapath peers.
// master = scheduler side, slave = control FSM, FM memory, MAC array and write-back sink.
interface comb_phase_scheduler_if #(
  parameter int unsigned ROW_BW = 3,
  parameter int unsigned K_BW   = 7
);
  logic              start;
  logic              busy;
  logic              done;
  logic              fm_rd_req;
  logic [ROW_BW-1:0] fm_rd_addr;
  logic              fm_rd_valid;
  logic              mac_clear;
  logic              mac_en;
  logic [K_BW-1:0]   mac_k;
  logic              res_valid;
  logic              res_ready;
  logic [ROW_BW-1:0] row_count;

  modport master (
    input  start, fm_rd_valid, res_ready,
    output busy, done, fm_rd_req, fm_rd_addr, mac_clear, mac_en, mac_k, res_valid, row_count
  );

  modport slave (
    output start, fm_rd_valid, res_ready,
    input  busy, done, fm_rd_req, fm_rd_addr, mac_clear, mac_en, mac_k, res_valid, row_count
  );
endinterface

// File: rtl/comb_phase_scheduler.sv
// Sequences the FM x WM combination phase row by row: fetch a row, run NUM_FEATURES MAC
// cycles, hand the result to write-back, and pulse done after the last row is accepted.
module comb_phase_scheduler #(
  parameter int unsigned NUM_ROWS     = 6,
  parameter int unsigned NUM_FEATURES = 96,
  parameter int unsigned ROW_BW       = $clog2(NUM_ROWS),
  parameter int unsigned K_BW         = $clog2(NUM_FEATURES)
) (
  input  logic                          clk,
  input  logic                          reset,
  comb_phase_scheduler_if.master        io_sched
);

  typedef enum logic [2:0] {StIdle, StFetch, StCompute, StWrite, StDone} state_e;

  localparam logic [ROW_BW-1:0] RowLast = ROW_BW'(NUM_ROWS - 1);
  localparam logic [K_BW-1:0]   KLast   = K_BW'(NUM_FEATURES - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [ROW_BW-1:0] r_row;
  logic [ROW_BW-1:0] w_row_next;
  logic [K_BW-1:0]   r_k;
  logic [K_BW-1:0]   w_k_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_k     <= w_k_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_k_next     = r_k;
    unique case (r_state)
      StIdle: begin
        if (io_sched.start) begin
          w_state_next = StFetch;
          w_row_next   = '0;
        end
      end
      StFetch: begin
        if (io_sched.fm_rd_valid) begin
          w_state_next = StCompute;
          w_k_next     = '0;
        end
      end
      StCompute: begin
        if (r_k == KLast) begin
          w_state_next = StWrite;
          w_k_next     = '0;
        end else begin
          w_k_next = r_k + 1'b1;
        end
      end
      StWrite: begin
        if (io_sched.res_ready) begin
          if (r_row == RowLast) begin
            w_state_next = StDone;
            w_row_next   = '0;
          end else begin
            w_state_next = StFetch;
            w_row_next   = r_row + 1'b1;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // All outputs are Moore decodes of the state so they are glitch-free and 0 in IDLE.
  assign io_sched.busy       = (r_state != StIdle);
  assign io_sched.done       = (r_state == StDone);
  assign io_sched.fm_rd_req  = (r_state == StFetch);
  assign io_sched.fm_rd_addr = r_row;
  assign io_sched.mac_en     = (r_state == StCompute);
  assign io_sched.mac_clear  = (r_state == StCompute) && (r_k == '0);
  assign io_sched.mac_k      = r_k;
  assign io_sched.res_valid  = (r_state == StWrite);
  assign io_sched.row_count  = r_row;

endmodule

// File: tb/tb_comb_phase_scheduler.sv
// Bench for comb_phase_scheduler: table of phase runs with per-row stall injection, plus
// hand sequences for reset, mid-run abort and start during DONE.
module tb_comb_phase_scheduler;

  localparam int NumRows = 6;
  localparam int NumFeat = 96;

  typedef struct {
    int frow;     // row whose fetch is stalled (-1 none)
    int fdelay;   // cycles fm_rd_valid is withheld
    int wrow;     // row whose write is stalled (-1 none)
    int wdelay;   // cycles res_ready is withheld
    int srow;     // row during whose COMPUTE a stray start is pulsed (-1 none)
    int exp_cyc;  // start cycle to done cycle
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comb_phase_scheduler_if #(.ROW_BW(3), .K_BW(7)) bus ();

  comb_phase_scheduler #(
    .NUM_ROWS    (NumRows),
    .NUM_FEATURES(NumFeat)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .io_sched(bus)
  );

  int   n_tests;
  int   n_fail;
  int   cyc;
  int   k_exp;
  int   fwait;
  int   wwait;
  int   done_cnt;
  int   xfer_cnt;
  int   req_cnt [8];
  int   sb [$];
  vec_t cur;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, check outputs, and set inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    bus.start       = 1'b0;
    bus.fm_rd_valid = 1'($urandom_range(0, 1));
    bus.res_ready   = 1'($urandom_range(0, 1));
    if (bus.fm_rd_req) begin
      req_cnt[bus.fm_rd_addr]++;
      k_exp = 0;
      if (sb.size() > 0) check("fetch_addr", int'(bus.fm_rd_addr), sb[0]);
      if (int'(bus.fm_rd_addr) == cur.frow && fwait < cur.fdelay) begin
        bus.fm_rd_valid = 1'b0;
        fwait++;
        check("fetch_stall_mac_en", int'(bus.mac_en), 0);
      end else begin
        bus.fm_rd_valid = 1'b1;
        fwait = 0;
      end
    end
    if (bus.mac_en) begin
      check("mac_k", int'(bus.mac_k), k_exp);
      check("mac_clear", int'(bus.mac_clear), (k_exp == 0) ? 1 : 0);
      k_exp++;
      if (int'(bus.row_count) == cur.srow && k_exp == 11) bus.start = 1'b1;
    end
    if (bus.res_valid) begin
      if (int'(bus.row_count) == cur.wrow && wwait < cur.wdelay) begin
        bus.res_ready = 1'b0;
        wwait++;
        check("write_stall_row", int'(bus.row_count), cur.wrow);
      end else begin
        bus.res_ready = 1'b1;
        wwait = 0;
        xfer_cnt++;
        if (sb.size() == 0) check("xfer_unexpected", int'(bus.row_count), -1);
        else check("xfer_row", int'(bus.row_count), sb.pop_front());
      end
    end
    if (bus.done) begin
      done_cnt++;
      check("done_busy", int'(bus.busy), 1);
    end
  endtask

  task automatic launch(input vec_t v);
    cur   = v;
    fwait = 0;
    wwait = 0;
    sb.delete();
    for (int r = 0; r < NumRows; r++) sb.push_back(r);
    tick();
    bus.start = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_done(output int got_cyc);
    got_cyc = -1;
    while (got_cyc < 0 && cyc < 3000) begin
      tick();
      if (bus.done) got_cyc = cyc;
    end
  endtask

  task automatic run_vector(input int idx);
    int d0, x0, got;
    int r0 [8];
    d0 = done_cnt;
    x0 = xfer_cnt;
    r0 = req_cnt;
    launch(vecs[idx]);
    wait_done(got);
    check($sformatf("v%0d_cycles", idx), got, vecs[idx].exp_cyc);
    tick();
    check($sformatf("v%0d_idle_busy", idx), int'(bus.busy), 0);
    check($sformatf("v%0d_done_once", idx), done_cnt - d0, 1);
    check($sformatf("v%0d_xfers", idx), xfer_cnt - x0, NumRows);
    check($sformatf("v%0d_sb_left", idx), sb.size(), 0);
    for (int r = 0; r < NumRows; r++)
      check($sformatf("v%0d_req_row%0d", idx, r), req_cnt[r] - r0[r],
            (r == vecs[idx].frow) ? vecs[idx].fdelay + 1 : 1);
  endtask

  initial begin
    int got;
    n_tests = 0;
    n_fail  = 0;
    k_exp = 0; done_cnt = 0; xfer_cnt = 0; cyc = 0;
    for (int r = 0; r < 8; r++) req_cnt[r] = 0;
    vecs[0] = '{frow: -1, fdelay: 0, wrow: -1, wdelay: 0, srow: -1, exp_cyc: 589};
    vecs[1] = '{frow:  2, fdelay: 5, wrow: -1, wdelay: 0, srow: -1, exp_cyc: 594};
    vecs[2] = '{frow: -1, fdelay: 0, wrow:  5, wdelay: 7, srow: -1, exp_cyc: 596};
    vecs[3] = '{frow: -1, fdelay: 0, wrow: -1, wdelay: 0, srow:  3, exp_cyc: 589};
    vecs[4] = '{frow:  0, fdelay: 3, wrow:  1, wdelay: 2, srow: -1, exp_cyc: 594};
    cur = vecs[0];
    rst = 1'b1;
    bus.start = 1'b0;
    bus.fm_rd_valid = 1'b0;
    bus.res_ready = 1'b0;

    // Reset, then idle with noise on the ignored inputs.
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_fm_rd_req", int'(bus.fm_rd_req), 0);
    check("rst_mac_en", int'(bus.mac_en), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_row_count", int'(bus.row_count), 0);
    check("rst_mac_k", int'(bus.mac_k), 0);

    for (int i = 0; i < 5; i++) run_vector(i);

    // Abort mid-phase at row 4, mac_k 40.
    launch(vecs[0]);
    got = 0;
    while (got == 0 && cyc < 3000) begin
      tick();
      if (bus.mac_en && bus.row_count == 3'd4 && bus.mac_k == 7'd40) got = 1;
    end
    check("abort_reached", got, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_row_count", int'(bus.row_count), 0);
    check("abort_mac_k", int'(bus.mac_k), 0);
    check("abort_mac_en", int'(bus.mac_en), 0);
    check("abort_fm_rd_req", int'(bus.fm_rd_req), 0);
    check("abort_res_valid", int'(bus.res_valid), 0);
    repeat (2) tick();
    run_vector(0);

    // start held during DONE must not launch another phase.
    launch(vecs[0]);
    wait_done(got);
    check("done_start_cycles", got, 589);
    bus.start = 1'b1;
    tick();
    check("done_start_ignored_busy", int'(bus.busy), 0);
    tick();
    check("done_start_still_idle", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
